// File: rtl/minmax_pkg.sv
// rtl/minmax_pkg.sv - shared types and signedness-aware compare helpers for minmax_scanner
package minmax_pkg;

  typedef enum logic [1:0] {IDLE, SCAN, REDUCE, DONE} state_t;

  // Helpers work on a 64-bit container so they serve any WIDTH up to 64.
  localparam int MAX_W = 64;

  function automatic int idx_w(input int depth);
    return $clog2(depth);
  endfunction

  function automatic logic [MAX_W-1:0] type_max(input int w, input bit sgn);
    logic [MAX_W-1:0] ones;
    ones = '1;
    return sgn ? (ones >> (MAX_W - w + 1)) : (ones >> (MAX_W - w));
  endfunction

  function automatic logic [MAX_W-1:0] type_min(input int w, input bit sgn);
    return sgn ? (MAX_W'(1) << (w - 1)) : '0;
  endfunction

  // Flipping the sign bit maps two's-complement order onto unsigned order.
  function automatic logic greater(input logic [MAX_W-1:0] a, input logic [MAX_W-1:0] b,
                                   input int w, input bit sgn);
    logic [MAX_W-1:0] flip;
    flip = sgn ? (MAX_W'(1) << (w - 1)) : '0;
    return (a ^ flip) > (b ^ flip);
  endfunction

endpackage

// File: rtl/minmax_lane.sv
// rtl/minmax_lane.sv - one lane's running max/min accumulator with index tracking
module minmax_lane
  import minmax_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int IDX_W  = 3,
  parameter int SIGNED = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             init,
  input  logic             update,
  input  logic [WIDTH-1:0] data,
  input  logic [IDX_W-1:0] idx,
  output logic [WIDTH-1:0] max,
  output logic [IDX_W-1:0] max_idx,
  output logic [WIDTH-1:0] min,
  output logic [IDX_W-1:0] min_idx
);

  localparam bit SGN = (SIGNED != 0);

  logic [MAX_W-1:0] data_x;
  logic [MAX_W-1:0] max_x;
  logic [MAX_W-1:0] min_x;

  assign data_x = MAX_W'(data);
  assign max_x  = MAX_W'(max);
  assign min_x  = MAX_W'(min);

  // Strict compares keep the earliest index, since entries arrive in ascending order.
  always_ff @(posedge clk) begin
    if (rst) begin
      max     <= '0;
      max_idx <= '0;
      min     <= '0;
      min_idx <= '0;
    end else if (init) begin
      max     <= WIDTH'(type_min(WIDTH, SGN));
      max_idx <= '0;
      min     <= WIDTH'(type_max(WIDTH, SGN));
      min_idx <= '0;
    end else if (update) begin
      if (greater(data_x, max_x, WIDTH, SGN)) begin
        max     <= data;
        max_idx <= idx;
      end
      if (greater(min_x, data_x, WIDTH, SGN)) begin
        min     <= data;
        min_idx <= idx;
      end
    end
  end

endmodule

// File: rtl/minmax_scanner.sv
// rtl/minmax_scanner.sv - register file with multi-lane min/max scan and registered results
module minmax_scanner
  import minmax_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int DEPTH  = 8,
  parameter int LANES  = 2,
  parameter int SIGNED = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     start,
  output logic                     wr_drop,
  output logic                     busy,
  output logic                     valid,
  output logic [WIDTH-1:0]         max,
  output logic [$clog2(DEPTH)-1:0] max_idx,
  output logic [WIDTH-1:0]         min,
  output logic [$clog2(DEPTH)-1:0] min_idx
);

  localparam int IDX_W = idx_w(DEPTH);
  localparam bit SGN   = (SIGNED != 0);

  state_t state;
  state_t next_state;

  logic scan_init;
  logic scan_update;
  logic reduce_load;
  logic accept_wr;

  logic [WIDTH-1:0] regs [DEPTH];
  logic [IDX_W-1:0] base;

  logic [WIDTH-1:0] lane_max     [LANES];
  logic [IDX_W-1:0] lane_max_idx [LANES];
  logic [WIDTH-1:0] lane_min     [LANES];
  logic [IDX_W-1:0] lane_min_idx [LANES];

  logic [WIDTH-1:0] red_max;
  logic [IDX_W-1:0] red_max_idx;
  logic [WIDTH-1:0] red_min;
  logic [IDX_W-1:0] red_min_idx;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state  = state;
    scan_init   = 1'b0;
    scan_update = 1'b0;
    reduce_load = 1'b0;
    accept_wr   = 1'b0;
    case (state)
      IDLE, DONE: begin
        accept_wr = wr_en;
        if (start) begin
          next_state = SCAN;
          scan_init  = 1'b1;
        end
      end
      SCAN: begin
        scan_update = 1'b1;
        if (base == IDX_W'(DEPTH - LANES)) next_state = REDUCE;
      end
      REDUCE: begin
        reduce_load = 1'b1;
        next_state  = DONE;
      end
      default: next_state = IDLE;
    endcase
  end

  assign busy = (state == SCAN) || (state == REDUCE);

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic [IDX_W-1:0] rd_idx;
    assign rd_idx = base + IDX_W'(l);

    minmax_lane #(
      .WIDTH (WIDTH),
      .IDX_W (IDX_W),
      .SIGNED(SIGNED)
    ) u_lane (
      .clk    (clk),
      .rst    (rst),
      .init   (scan_init),
      .update (scan_update),
      .data   (regs[rd_idx]),
      .idx    (rd_idx),
      .max    (lane_max[l]),
      .max_idx(lane_max_idx[l]),
      .min    (lane_min[l]),
      .min_idx(lane_min_idx[l])
    );
  end

  // Fold the lanes; on equal values the lower index wins.
  always_comb begin
    red_max     = lane_max[0];
    red_max_idx = lane_max_idx[0];
    red_min     = lane_min[0];
    red_min_idx = lane_min_idx[0];
    for (int l = 1; l < LANES; l++) begin
      if (greater(MAX_W'(lane_max[l]), MAX_W'(red_max), WIDTH, SGN) ||
          (lane_max[l] == red_max && lane_max_idx[l] < red_max_idx)) begin
        red_max     = lane_max[l];
        red_max_idx = lane_max_idx[l];
      end
      if (greater(MAX_W'(red_min), MAX_W'(lane_min[l]), WIDTH, SGN) ||
          (lane_min[l] == red_min && lane_min_idx[l] < red_min_idx)) begin
        red_min     = lane_min[l];
        red_min_idx = lane_min_idx[l];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
      base    <= '0;
      wr_drop <= 1'b0;
      valid   <= 1'b0;
      max     <= '0;
      max_idx <= '0;
      min     <= '0;
      min_idx <= '0;
    end else begin
      wr_drop <= wr_en && busy;
      if (accept_wr) regs[wr_addr] <= wr_data;
      if (scan_init) begin
        base  <= '0;
        valid <= 1'b0;
      end else if (scan_update) begin
        base <= base + IDX_W'(LANES);
      end
      if (reduce_load) begin
        max     <= red_max;
        max_idx <= red_max_idx;
        min     <= red_min;
        min_idx <= red_min_idx;
        valid   <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_minmax_scanner.sv
// tb/tb_minmax_scanner.sv - self-checking bench for minmax_scanner against a behavioural model
module tb_minmax_scanner;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [15:0] wr_data;
  logic        start;

  logic        u_drop, u_busy, u_valid;
  logic [15:0] u_max, u_min;
  logic [2:0]  u_max_idx, u_min_idx;
  logic        s_drop, s_busy, s_valid;
  logic [15:0] s_max, s_min;
  logic [2:0]  s_max_idx, s_min_idx;
  logic        b_drop, b_busy, b_valid;
  logic [15:0] b_max, b_min;
  logic [3:0]  b_max_idx, b_min_idx;

  logic [15:0] mem_a [8];
  logic [15:0] mem_b [16];

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  minmax_scanner #(.WIDTH(16), .DEPTH(8), .LANES(2), .SIGNED(0)) dut_u (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr[2:0]), .wr_data(wr_data),
    .start(start), .wr_drop(u_drop), .busy(u_busy), .valid(u_valid),
    .max(u_max), .max_idx(u_max_idx), .min(u_min), .min_idx(u_min_idx));

  minmax_scanner #(.WIDTH(16), .DEPTH(8), .LANES(2), .SIGNED(1)) dut_s (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr[2:0]), .wr_data(wr_data),
    .start(start), .wr_drop(s_drop), .busy(s_busy), .valid(s_valid),
    .max(s_max), .max_idx(s_max_idx), .min(s_min), .min_idx(s_min_idx));

  minmax_scanner #(.WIDTH(16), .DEPTH(16), .LANES(4), .SIGNED(0)) dut_b (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .start(start), .wr_drop(b_drop), .busy(b_busy), .valid(b_valid),
    .max(b_max), .max_idx(b_max_idx), .min(b_min), .min_idx(b_min_idx));

  // Reference: first occurrence of the extreme value in plain integer order.
  function automatic void ref_scan(input bit use_b, input bit sgn,
                                   output logic [15:0] mx, output int mxi,
                                   output logic [15:0] mn, output int mni);
    int n;
    longint v, hi, lo;
    logic [15:0] w;
    n = use_b ? 16 : 8;
    hi = 0; lo = 0; mx = '0; mn = '0; mxi = 0; mni = 0;
    for (int i = 0; i < n; i++) begin
      w = use_b ? mem_b[i] : mem_a[i];
      v = sgn ? longint'($signed(w)) : longint'(w);
      if (i == 0 || v > hi) begin hi = v; mx = w; mxi = i; end
      if (i == 0 || v < lo) begin lo = v; mn = w; mni = i; end
    end
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_model;
    for (int i = 0; i < 8; i++) mem_a[i] = '0;
    for (int i = 0; i < 16; i++) mem_b[i] = '0;
  endtask

  task automatic write(input logic [3:0] a, input logic [15:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    tick;
    wr_en = 1'b0;
    mem_a[a[2:0]] = d;
    mem_b[a] = d;
  endtask

  // Optionally pairs a write with the start edge; samples busy/valid after edges 0..5.
  task automatic run_scan(input bit with_wr, input logic [3:0] a, input logic [15:0] d,
                          output logic [5:0] bseq, output logic [5:0] vseq,
                          output logic [5:0] bseq_b, output logic [5:0] vseq_b);
    start = 1'b1;
    if (with_wr) begin
      wr_en = 1'b1; wr_addr = a; wr_data = d;
      mem_a[a[2:0]] = d;
      mem_b[a] = d;
    end
    tick;
    start = 1'b0; wr_en = 1'b0;
    for (int k = 0; k < 6; k++) begin
      if (k > 0) tick;
      bseq[k] = u_busy; vseq[k] = u_valid;
      bseq_b[k] = b_busy; vseq_b[k] = b_valid;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; wr_en = 1'b0; start = 1'b0; wr_addr = '0; wr_data = '0;
    tick; tick;
    rst = 1'b0;
    clear_model();
    n_vec++;
    if ({u_busy, u_valid, u_drop, u_max, u_max_idx, u_min, u_min_idx} !== '0) begin
      n_err++; $display("FAIL reset_u: got %h required 0", {u_busy, u_valid, u_drop, u_max, u_max_idx, u_min, u_min_idx});
    end
    n_vec++;
    if ({s_busy, s_valid, s_drop, s_max, s_max_idx, s_min, s_min_idx} !== '0) begin
      n_err++; $display("FAIL reset_s: got %h required 0", {s_busy, s_valid, s_drop, s_max, s_max_idx, s_min, s_min_idx});
    end
    n_vec++;
    if ({b_busy, b_valid, b_drop, b_max, b_max_idx, b_min, b_min_idx} !== '0) begin
      n_err++; $display("FAIL reset_b: got %h required 0", {b_busy, b_valid, b_drop, b_max, b_max_idx, b_min, b_min_idx});
    end
  endtask

  task automatic test_directed;
    logic [15:0] vals [8];
    logic [5:0] bs, vs, bb, vb;
    logic [15:0] mx, mn; int mxi, mni;
    vals = '{16'd5, 16'd3, 16'd9, 16'd1, 16'd7, 16'd2, 16'd8, 16'd4};
    for (int i = 0; i < 8; i++) write(4'(i), vals[i]);
    run_scan(1'b0, 4'd0, 16'd0, bs, vs, bb, vb);
    ref_scan(1'b0, 1'b0, mx, mxi, mn, mni);
    n_vec++;
    if (bs !== 6'b011111) begin n_err++; $display("FAIL directed_busy: got %b required 011111", bs); end
    n_vec++;
    if (vs !== 6'b100000) begin n_err++; $display("FAIL directed_valid: got %b required 100000", vs); end
    n_vec++;
    if ({u_max, u_max_idx, u_min, u_min_idx} !== {16'd9, 3'd2, 16'd1, 3'd3}) begin
      n_err++; $display("FAIL directed_const: got %h required %h", {u_max, u_max_idx, u_min, u_min_idx}, {16'd9, 3'd2, 16'd1, 3'd3});
    end
    n_vec++;
    if ({u_max, u_max_idx, u_min, u_min_idx} !== {mx, 3'(mxi), mn, 3'(mni)}) begin
      n_err++; $display("FAIL directed_model: got %h required %h", {u_max, u_max_idx, u_min, u_min_idx}, {mx, 3'(mxi), mn, 3'(mni)});
    end
  endtask

  task automatic test_all_equal;
    logic [5:0] bs, vs, bb, vb;
    for (int i = 0; i < 8; i++) write(4'(i), 16'h1234);
    run_scan(1'b0, 4'd0, 16'd0, bs, vs, bb, vb);
    n_vec++;
    if ({u_valid, u_max, u_max_idx, u_min, u_min_idx} !== {1'b1, 16'h1234, 3'd0, 16'h1234, 3'd0}) begin
      n_err++; $display("FAIL all_equal: got %h required %h", {u_valid, u_max, u_max_idx, u_min, u_min_idx}, {1'b1, 16'h1234, 3'd0, 16'h1234, 3'd0});
    end
  endtask

  task automatic test_signedness;
    logic [15:0] vals [8];
    logic [5:0] bs, vs, bb, vb;
    vals = '{16'h0000, 16'hFFFF, 16'h8000, 16'h7FFF, 16'd1, 16'd1, 16'd1, 16'd1};
    for (int i = 0; i < 8; i++) write(4'(i), vals[i]);
    run_scan(1'b0, 4'd0, 16'd0, bs, vs, bb, vb);
    n_vec++;
    if ({u_max, u_max_idx, u_min, u_min_idx} !== {16'hFFFF, 3'd1, 16'h0000, 3'd0}) begin
      n_err++; $display("FAIL unsigned_cmp: got %h required %h", {u_max, u_max_idx, u_min, u_min_idx}, {16'hFFFF, 3'd1, 16'h0000, 3'd0});
    end
    n_vec++;
    if ({s_valid, s_max, s_max_idx, s_min, s_min_idx} !== {1'b1, 16'h7FFF, 3'd3, 16'h8000, 3'd2}) begin
      n_err++; $display("FAIL signed_cmp: got %h required %h", {s_valid, s_max, s_max_idx, s_min, s_min_idx}, {1'b1, 16'h7FFF, 3'd3, 16'h8000, 3'd2});
    end
  endtask

  task automatic test_random;
    logic [15:0] pool [4];
    logic [5:0] bs, vs, bb, vb;
    logic [15:0] mx, mn, d; int mxi, mni;
    bit tie_mode;
    pool = '{16'h0000, 16'hFFFF, 16'h8000, 16'h7FFF};
    for (int it = 0; it < 24; it++) begin
      tie_mode = it[0];
      for (int i = 0; i < 8; i++) begin
        d = tie_mode ? pool[$urandom_range(3, 0)] : 16'($urandom);
        if (i < 7) write(4'(i), d);
      end
      run_scan(1'b1, 4'd7, d, bs, vs, bb, vb);
      ref_scan(1'b0, 1'b0, mx, mxi, mn, mni);
      n_vec++;
      if ({u_valid, u_max, u_max_idx, u_min, u_min_idx} !== {1'b1, mx, 3'(mxi), mn, 3'(mni)}) begin
        n_err++; $display("FAIL random_u[%0d]: got %h required %h", it, {u_valid, u_max, u_max_idx, u_min, u_min_idx}, {1'b1, mx, 3'(mxi), mn, 3'(mni)});
      end
      ref_scan(1'b0, 1'b1, mx, mxi, mn, mni);
      n_vec++;
      if ({s_valid, s_max, s_max_idx, s_min, s_min_idx} !== {1'b1, mx, 3'(mxi), mn, 3'(mni)}) begin
        n_err++; $display("FAIL random_s[%0d]: got %h required %h", it, {s_valid, s_max, s_max_idx, s_min, s_min_idx}, {1'b1, mx, 3'(mxi), mn, 3'(mni)});
      end
    end
  endtask

  task automatic test_busy_write;
    logic [15:0] vals [8];
    logic [5:0] bs, vs, bb, vb;
    vals = '{16'd5, 16'd3, 16'd9, 16'd1, 16'd7, 16'd2, 16'd8, 16'd4};
    for (int i = 0; i < 8; i++) write(4'(i), vals[i]);
    start = 1'b1; tick;
    start = 1'b0; tick;
    wr_en = 1'b1; wr_addr = 4'd3; wr_data = 16'd0; start = 1'b1;
    tick;
    wr_en = 1'b0; start = 1'b0;
    n_vec++;
    if (u_drop !== 1'b1) begin n_err++; $display("FAIL drop_pulse: got %b required 1", u_drop); end
    tick;
    n_vec++;
    if (u_drop !== 1'b0) begin n_err++; $display("FAIL drop_clear: got %b required 0", u_drop); end
    tick;
    n_vec++;
    if ({u_busy, u_valid} !== 2'b10) begin n_err++; $display("FAIL busy_edge4: got %b required 10", {u_busy, u_valid}); end
    tick;
    n_vec++;
    if ({u_busy, u_valid, u_max, u_max_idx, u_min, u_min_idx} !== {2'b01, 16'd9, 3'd2, 16'd1, 3'd3}) begin
      n_err++; $display("FAIL busy_write_result: got %h required %h", {u_busy, u_valid, u_max, u_max_idx, u_min, u_min_idx}, {2'b01, 16'd9, 3'd2, 16'd1, 3'd3});
    end
    run_scan(1'b0, 4'd0, 16'd0, bs, vs, bb, vb);
    n_vec++;
    if ({bs, vs} !== {6'b011111, 6'b100000}) begin n_err++; $display("FAIL restart_seq: got %b required 011111100000", {bs, vs}); end
    n_vec++;
    if ({u_max, u_max_idx, u_min, u_min_idx} !== {16'd9, 3'd2, 16'd1, 3'd3}) begin
      n_err++; $display("FAIL restart_result: got %h required %h", {u_max, u_max_idx, u_min, u_min_idx}, {16'd9, 3'd2, 16'd1, 3'd3});
    end
  endtask

  task automatic test_reset_mid;
    logic [5:0] bs, vs, bb, vb;
    for (int i = 0; i < 8; i++) write(4'(i), 16'($urandom) | 16'h0001);
    start = 1'b1; tick;
    start = 1'b0; tick; tick;
    rst = 1'b1; tick;
    rst = 1'b0;
    clear_model();
    n_vec++;
    if ({u_busy, u_valid, u_drop, u_max, u_max_idx, u_min, u_min_idx} !== '0) begin
      n_err++; $display("FAIL mid_reset: got %h required 0", {u_busy, u_valid, u_drop, u_max, u_max_idx, u_min, u_min_idx});
    end
    run_scan(1'b0, 4'd0, 16'd0, bs, vs, bb, vb);
    n_vec++;
    if ({u_valid, u_max, u_max_idx, u_min, u_min_idx} !== {1'b1, 16'd0, 3'd0, 16'd0, 3'd0}) begin
      n_err++; $display("FAIL post_reset_scan: got %h required %h", {u_valid, u_max, u_max_idx, u_min, u_min_idx}, {1'b1, 16'd0, 3'd0, 16'd0, 3'd0});
    end
  endtask

  task automatic test_lanes4;
    logic [5:0] bs, vs, bb, vb;
    logic [15:0] mx, mn; int mxi, mni;
    for (int i = 0; i < 16; i++) write(4'(i), 16'(100 - i));
    run_scan(1'b0, 4'd0, 16'd0, bs, vs, bb, vb);
    n_vec++;
    if ({bb, vb} !== {6'b011111, 6'b100000}) begin n_err++; $display("FAIL lanes4_seq: got %b required 011111100000", {bb, vb}); end
    n_vec++;
    if ({b_max, b_max_idx, b_min, b_min_idx} !== {16'd100, 4'd0, 16'd85, 4'd15}) begin
      n_err++; $display("FAIL lanes4_const: got %h required %h", {b_max, b_max_idx, b_min, b_min_idx}, {16'd100, 4'd0, 16'd85, 4'd15});
    end
    for (int it = 0; it < 6; it++) begin
      for (int i = 0; i < 16; i++) write(4'(i), 16'($urandom_range(7, 0)) << it);
      run_scan(1'b0, 4'd0, 16'd0, bs, vs, bb, vb);
      ref_scan(1'b1, 1'b0, mx, mxi, mn, mni);
      n_vec++;
      if ({b_valid, b_max, b_max_idx, b_min, b_min_idx} !== {1'b1, mx, 4'(mxi), mn, 4'(mni)}) begin
        n_err++; $display("FAIL lanes4_random[%0d]: got %h required %h", it, {b_valid, b_max, b_max_idx, b_min, b_min_idx}, {1'b1, mx, 4'(mxi), mn, 4'(mni)});
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_all_equal();
    test_signedness();
    test_random();
    test_busy_write();
    test_reset_mid();
    test_lanes4();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
